// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-light controller.
// The LFSR step function lives here so every user agrees on the polynomial.
package f1_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COUNTUP = 3'd1,
        HOLD    = 3'd2,
        TIMING  = 3'd3,
        DONE    = 3'd4,
        FAULT   = 3'd5
    } state_e;

    localparam logic [7:0] LIGHTS_ALL = 8'hFF;
    localparam logic [6:0] LFSR_SEED  = 7'h01;

    // Fibonacci form of x^7 + x^6 + 1: maximal length (127 states), zero never reached.
    function automatic logic [6:0] lfsr_step(input logic [6:0] v);
        return {v[5:0], v[6] ^ v[5]};
    endfunction

endpackage

// File: rtl/f1_lfsr.sv
// Free-running 7-bit LFSR used to randomise the all-lit hold time.
module f1_lfsr
    import f1_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [6:0] lfsr_o
);

    logic [6:0] lfsr_q;
    logic [6:0] lfsr_d;

    assign lfsr_d = lfsr_step(lfsr_q);
    assign lfsr_o = lfsr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/f1_start_controller.sv
// Sequences the start lights, holds for a random time, then measures the driver's
// reaction from lights-out to the button's rising edge; early presses flag a jump start.
module f1_start_controller
    import f1_pkg::*;
#(
    parameter int TICK_CYCLES = 1000,
    parameter int MIN_DELAY   = 2000,
    parameter int DELAY_SHIFT = 4,
    parameter int TIME_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trigger_i,
    input  logic              react_i,
    input  logic [7:0]        lights_i,
    output logic              fsm_en_o,
    output logic              fsm_rst_o,
    output logic              busy_o,
    output logic              result_valid_o,
    output logic [TIME_W-1:0] reaction_time_o,
    output logic              jump_start_o
);

    localparam int TICK_W    = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam int DELAY_MAX = MIN_DELAY + (127 << DELAY_SHIFT);
    localparam int DELAY_W   = $clog2(DELAY_MAX + 1);

    localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam logic [DELAY_W-1:0] DELAY_MIN = DELAY_W'(MIN_DELAY);
    localparam logic [TIME_W-1:0]  TIME_MAX  = {TIME_W{1'b1}};

    state_e             state_q, state_d;
    logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [DELAY_W-1:0] delay_cnt_q, delay_cnt_d;
    logic [TIME_W-1:0]  time_cnt_q, time_cnt_d;
    logic [TIME_W-1:0]  reaction_time_q, reaction_time_d;
    logic               fsm_en_q, fsm_en_d;
    logic               result_valid_q, result_valid_d;
    logic               jump_start_q, jump_start_d;
    logic               react_q;
    logic               react_rise;
    logic [6:0]         lfsr;
    logic [DELAY_W-1:0] delay_load;

    f1_lfsr u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .lfsr_o (lfsr)
    );

    assign react_rise = react_i & ~react_q;
    assign delay_load = DELAY_MIN + (DELAY_W'(lfsr) << DELAY_SHIFT);

    always_comb begin
        state_d         = state_q;
        tick_cnt_d      = tick_cnt_q;
        delay_cnt_d     = delay_cnt_q;
        time_cnt_d      = time_cnt_q;
        reaction_time_d = reaction_time_q;
        fsm_en_d        = 1'b0;
        result_valid_d  = 1'b0;
        jump_start_d    = jump_start_q;

        case (state_q)
            IDLE: begin
                if (trigger_i) begin
                    state_d      = COUNTUP;
                    tick_cnt_d   = '0;
                    jump_start_d = 1'b0;
                end
            end
            COUNTUP: begin
                // Lights reach FF one cycle after the 8th tick, before another tick is due.
                if (react_rise) begin
                    state_d = FAULT;
                end else if (lights_i == LIGHTS_ALL) begin
                    state_d     = HOLD;
                    delay_cnt_d = delay_load;
                end else if (tick_cnt_q == TICK_LAST) begin
                    fsm_en_d   = 1'b1;
                    tick_cnt_d = '0;
                end else begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (react_rise) begin
                    state_d = FAULT;
                end else if (delay_cnt_q == '0) begin
                    fsm_en_d   = 1'b1;
                    state_d    = TIMING;
                    time_cnt_d = '0;
                end else begin
                    delay_cnt_d = delay_cnt_q - 1'b1;
                end
            end
            TIMING: begin
                // result_valid is raised on entry so it is high exactly while in DONE.
                if (react_rise) begin
                    state_d         = DONE;
                    reaction_time_d = time_cnt_q;
                    result_valid_d  = 1'b1;
                end else if (time_cnt_q == TIME_MAX) begin
                    state_d         = DONE;
                    reaction_time_d = TIME_MAX;
                    result_valid_d  = 1'b1;
                end else begin
                    time_cnt_d = time_cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            FAULT: begin
                jump_start_d = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            tick_cnt_q      <= '0;
            delay_cnt_q     <= '0;
            time_cnt_q      <= '0;
            reaction_time_q <= '0;
            fsm_en_q        <= 1'b0;
            result_valid_q  <= 1'b0;
            jump_start_q    <= 1'b0;
            react_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            tick_cnt_q      <= tick_cnt_d;
            delay_cnt_q     <= delay_cnt_d;
            time_cnt_q      <= time_cnt_d;
            reaction_time_q <= reaction_time_d;
            fsm_en_q        <= fsm_en_d;
            result_valid_q  <= result_valid_d;
            jump_start_q    <= jump_start_d;
            react_q         <= react_i;
        end
    end

    assign fsm_en_o        = fsm_en_q;
    assign fsm_rst_o       = (state_q == IDLE);
    assign busy_o          = (state_q != IDLE);
    assign result_valid_o  = result_valid_q;
    assign reaction_time_o = reaction_time_q;
    assign jump_start_o    = jump_start_q;

endmodule

// File: tb/tb_f1_start_controller.sv
// Directed bench for f1_start_controller with a behavioural 8-light FSM attached.
module tb_f1_start_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       trigger_i;
    logic       react_i;
    logic [7:0] lights_i;
    logic       fsm_en_o;
    logic       fsm_rst_o;
    logic       busy_o;
    logic       result_valid_o;
    logic [7:0] reaction_time_o;
    logic       jump_start_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    f1_start_controller #(
        .TICK_CYCLES (4),
        .MIN_DELAY   (10),
        .DELAY_SHIFT (0),
        .TIME_W      (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .trigger_i       (trigger_i),
        .react_i         (react_i),
        .lights_i        (lights_i),
        .fsm_en_o        (fsm_en_o),
        .fsm_rst_o       (fsm_rst_o),
        .busy_o          (busy_o),
        .result_valid_o  (result_valid_o),
        .reaction_time_o (reaction_time_o),
        .jump_start_o    (jump_start_o)
    );

    function automatic logic [7:0] lit(input int n);
        logic [8:0] v;
        v = (9'd1 << n) - 9'd1;
        return v[7:0];
    endfunction

    // Light FSM: S0..S8, one light added per enable, S8 wraps to S0.
    logic [3:0] light_st;
    always @(posedge clk) begin
        if (fsm_rst_o)     light_st <= 4'd0;
        else if (fsm_en_o) light_st <= (light_st == 4'd8) ? 4'd0 : light_st + 4'd1;
    end
    assign lights_i = lit(int'(light_st));

    // Reference LFSR, x^7 + x^6 + 1, seeded with 1 on reset.
    logic [6:0] lfsr_m;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) lfsr_m <= 7'h01;
        else     lfsr_m <= {lfsr_m[5:0], lfsr_m[6] ^ lfsr_m[5]};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_trigger();
        @(negedge clk);
        trigger_i = 1'b1;
        @(negedge clk);
        trigger_i = 1'b0;
    endtask

    // Trigger, check the countup and hold, then raise react k cycles after the expiry pulse.
    task automatic run_seq(input int k, input logic [7:0] exp_time);
        int npulse = 0, last = 0, t_ff = -1, d = 0, vat = -1, vcnt = 0, exp_at;
        logic [7:0] vtime = 8'h00;
        bit found = 0;
        pulse_trigger();
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (fsm_en_o) begin
                npulse++;
                if (npulse <= 8) begin
                    chk($sformatf("lights_before_pulse%0d", npulse), lights_i, lit(npulse - 1));
                    if (npulse > 1) chk("tick_spacing", cyc - last, 4);
                end else begin
                    chk("hold_length", cyc - t_ff, d + 2);
                    found = 1;
                end
                last = cyc;
            end
            if (!found && t_ff < 0 && lights_i == 8'hFF) begin
                t_ff = cyc;
                d = 10 + int'(lfsr_m);
            end
        end
        if (!found) chk("expiry_pulse_timeout", 0, 1);
        exp_at = ((k < 255) ? k : 255) + 1;
        if (k == 0) react_i = 1'b1;
        for (int i = 1; i <= exp_at + 1; i++) begin
            @(negedge clk);
            if (i == 1) chk("lights_cleared", lights_i, 0);
            if (result_valid_o) begin
                vcnt++;
                if (vat < 0) begin
                    vat = i;
                    vtime = reaction_time_o;
                end
            end
            if (i == k) react_i = 1'b1;
        end
        $display("run react_after=%0d valid_at=%0d reaction_time=%0d", k, vat, vtime);
        chk("valid_cycle", vat, exp_at);
        chk("valid_width", vcnt, 1);
        chk("reaction_time", vtime, exp_time);
        chk("jump_start_clear", jump_start_o, 0);
        chk("idle_after_done", busy_o, 0);
        react_i = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        int         react_after;
        logic [7:0] exp_time;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int n_en, n_norst, n_busy, n_lit;
        bit hit;

        vecs[0] = '{25,  8'd25};
        vecs[1] = '{0,   8'd0};
        vecs[2] = '{1,   8'd1};
        vecs[3] = '{100, 8'd100};
        vecs[4] = '{254, 8'd254};
        vecs[5] = '{255, 8'd255};
        vecs[6] = '{300, 8'hFF};

        rst = 1'b1;
        trigger_i = 1'b0;
        react_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset: nothing moves.
        n_en = 0; n_norst = 0; n_busy = 0; n_lit = 0;
        chk("rst_result_valid", result_valid_o, 0);
        chk("rst_reaction_time", reaction_time_o, 0);
        chk("rst_jump_start", jump_start_o, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_en    += int'(fsm_en_o);
            n_norst += int'(!fsm_rst_o);
            n_busy  += int'(busy_o);
            n_lit   += int'(lights_i != 8'h00);
        end
        $display("idle 20 cycles: en=%0d norst=%0d busy=%0d lit=%0d", n_en, n_norst, n_busy, n_lit);
        chk("idle_fsm_en", n_en, 0);
        chk("idle_fsm_rst", n_norst, 0);
        chk("idle_busy", n_busy, 0);
        chk("idle_lights", n_lit, 0);

        foreach (vecs[v]) run_seq(vecs[v].react_after, vecs[v].exp_time);

        // Jump start: press while lights show 07.
        pulse_trigger();
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (lights_i == 8'h07) hit = 1;
        end
        chk("reach_lights_07", hit, 1);
        react_i = 1'b1;
        n_en = 0;
        @(negedge clk);
        n_en += int'(result_valid_o);
        @(negedge clk);
        n_en += int'(result_valid_o);
        $display("jump start: jump_start=%0d busy=%0d", jump_start_o, busy_o);
        chk("jump_start_set", jump_start_o, 1);
        chk("jump_idle", busy_o, 0);
        chk("jump_fsm_rst", fsm_rst_o, 1);
        @(negedge clk);
        n_en += int'(result_valid_o);
        chk("jump_lights_off", lights_i, 0);
        chk("jump_no_result", n_en, 0);

        // React held across trigger: no fault, jump flag cleared; then reset inside HOLD.
        pulse_trigger();
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (lights_i == 8'hFF) hit = 1;
        end
        chk("held_react_reach_ff", hit, 1);
        chk("held_react_jump_clear", jump_start_o, 0);
        react_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("hold_busy", busy_o, 1);
        chk("pre_rst_reaction_time", reaction_time_o, 8'hFF);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("rst in hold: busy=%0d fsm_rst=%0d reaction_time=%0d", busy_o, fsm_rst_o, reaction_time_o);
        chk("rst_hold_busy", busy_o, 0);
        chk("rst_hold_fsm_rst", fsm_rst_o, 1);
        chk("rst_hold_fsm_en", fsm_en_o, 0);
        chk("rst_hold_valid", result_valid_o, 0);
        chk("rst_hold_time", reaction_time_o, 0);
        chk("rst_hold_jump", jump_start_o, 0);
        @(negedge clk);
        chk("rst_hold_lights", lights_i, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
